// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters, one frame per grant.
// Define SPI_ARB_TIMEOUT_EN to abort a launch that never sees cs fall (err pulse, no done).
module spi_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DW          = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_din,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic                  new_data,
    output logic [DW-1:0]         din,
    input  logic                  cs
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_cs_q;
    logic [PW-1:0]        r_rr_ptr;
    logic [PW-1:0]        r_sel;
    logic [PW-1:0]        w_pick;
    logic [PW-1:0]        w_sel_inc;
    logic                 w_found;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_new_data;
    logic [DW-1:0]        r_din;

    // Scan downwards so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        w_pick  = '0;
        w_found = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_pick = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_sel_inc = (r_sel == PW'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found && r_cs_q) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (!r_cs_q)        w_next = S_BUSY;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_BUSY: begin
                if (r_cs_q) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_q     <= 1'b1;
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_new_data <= 1'b0;
            r_din      <= '0;
        end else begin
            r_cs_q <= cs;
            r_done <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found && r_cs_q) begin
                        r_sel      <= w_pick;
                        r_gnt      <= NUM_REQ'(1) << w_pick;
                        r_din      <= req_din[int'(w_pick)*DW +: DW];
                        r_new_data <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (!r_cs_q) begin
                        r_new_data <= 1'b0;
                    end else if (w_timeout) begin
                        r_new_data <= 1'b0;
                        r_gnt      <= '0;
                        r_rr_ptr   <= w_sel_inc;
                    end
                end
                S_BUSY: begin
                    if (r_cs_q) r_done <= r_gnt;
                end
                S_DONE: begin
                    r_gnt    <= '0;
                    r_rr_ptr <= w_sel_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0]      r_timer;
    logic [NUM_REQ-1:0] r_err;

    // Timer idles at zero outside LAUNCH, so every launch starts a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
            r_err   <= '0;
        end else begin
            r_err <= '0;
            if (r_state != S_LAUNCH) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
                if (w_timeout) r_err <= r_gnt;
            end
        end
    end

    assign w_timeout = (r_state == S_LAUNCH) && r_cs_q &&
                       (r_timer == TW'(TIMEOUT_CYC - 1));
    assign err       = r_err;
`else
    assign w_timeout = 1'b0 && (TIMEOUT_CYC > 0);
    assign err       = '0;
`endif

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign new_data = r_new_data;
    assign din      = r_din;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: behavioural spi_master stand-in plus round-robin reference model.
// Timeout scenario compiles only with SPI_ARB_TIMEOUT_EN.
module tb_spi_master_arbiter;

    localparam int N   = 4;
    localparam int DW  = 12;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_din = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic            new_data;
    logic [DW-1:0]   din;
    logic            cs;

    int compared   = 0;
    int mismatched = 0;
    int rr_m       = 0;

    logic          spi_hold = 1'b0;
    logic          busy;
    logic [DW-1:0] sh;
    logic [DW-1:0] rx;
    logic [DW-1:0] rx_word;
    int            bitn;
    int            nframes = 0;

    spi_master_arbiter #(
        .NUM_REQ    (N),
        .DW         (DW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_din (req_din),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .new_data(new_data),
        .din     (din),
        .cs      (cs)
    );

    always #5 clk = ~clk;

    // spi_master stand-in: latch din on new_data, shift it out LSB-first, rebuild it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs   <= 1'b1;
            busy <= 1'b0;
            bitn <= 0;
        end else if (!busy) begin
            if (new_data && !spi_hold) begin
                busy <= 1'b1;
                sh   <= din;
                bitn <= 0;
                cs   <= 1'b0;
            end
        end else if (bitn < DW) begin
            rx[bitn] <= sh[0];
            sh       <= sh >> 1;
            bitn     <= bitn + 1;
        end else begin
            cs      <= 1'b1;
            busy    <= 1'b0;
            rx_word <= rx;
            nframes <= nframes + 1;
        end
    end

    task automatic apply_reset();
        rst      = 1'b0;
        req      = '0;
        spi_hold = 1'b0;
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        rr_m = 0;
        @(negedge clk);
    endtask

    // One frame: predict owner from req and rr_m, then follow grant to done.
    task automatic serve(input bit release_owner, input bit mutate, output int who);
        int            ex;
        int            t;
        int            nf;
        logic [DW-1:0] w;
        logic [N-1:0]  oh;
        ex = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(rr_m + k) % N]) ex = (rr_m + k) % N;
        end
        who = ex;
        oh  = '0;
        oh[ex] = 1'b1;
        w  = req_din[ex*DW +: DW];
        nf = nframes;
        t  = 0;
        do begin
            @(negedge clk);
            t++;
        end while (gnt == '0 && t < 200);
        compared++;
        if (gnt !== oh || din !== w || new_data !== 1'b1) begin
            mismatched++;
            $display("FAIL grant: gnt=%b din=%h nd=%b, required gnt=%b din=%h nd=1", gnt, din, new_data, oh, w);
            return;
        end
        if (mutate) begin
            t = 0;
            while (cs !== 1'b0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            req_din[ex*DW +: DW] = '1;
            req[ex] = 1'b0;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done == '0 && t < 200);
        compared++;
        if (done !== oh || rx_word !== w || din !== w || nframes !== nf + 1) begin
            mismatched++;
            $display("FAIL done: done=%b sent=%h din=%h frames=%0d, required done=%b sent=%h frames=%0d", done, rx_word, din, nframes - nf, oh, w, 1);
        end
        if (release_owner) req[ex] = 1'b0;
        @(negedge clk);
        compared++;
        if (done !== '0 || gnt !== '0) begin
            mismatched++;
            $display("FAIL done_pulse: done=%b gnt=%b, required 0 and 0", done, gnt);
        end
        rr_m = (ex + 1) % N;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        req     = '0;
        req_din = {$urandom, $urandom};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            compared++;
            if ({gnt, done, err, new_data, din} !== '0) begin
                mismatched++;
                $display("FAIL reset: gnt=%b done=%b err=%b nd=%b din=%h, required all 0", gnt, done, err, new_data, din);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int who;
        apply_reset();
        req_din[2*DW +: DW] = 12'hA5C;
        req = 4'b0100;
        serve(1'b1, 1'b0, who);
        compared++;
        if (who !== 2) begin
            mismatched++;
            $display("FAIL single_owner: got %0d, required 2", who);
        end
    endtask

    task automatic test_back_to_back();
        int who;
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req_din = {12'h008, 12'h004, 12'h002, 12'h001};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(1'b0, 1'b0, who);
            compared++;
            if (who !== order[i]) begin
                mismatched++;
                $display("FAIL rr_order[%0d]: got %0d, required %0d", i, who, order[i]);
            end
        end
        req = '0;
    endtask

    task automatic test_mid_change();
        int who;
        req_din[1*DW +: DW] = 12'h3C6;
        req = 4'b0010;
        serve(1'b1, 1'b1, who);
    endtask

    task automatic test_rst_mid();
        int t;
        int who;
        apply_reset();
        req_din[0 +: DW] = DW'($urandom);
        req = 4'b0001;
        t = 0;
        while ((gnt === '0 || cs !== 1'b0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (gnt !== '0 || new_data !== 1'b0 || din !== '0) begin
            mismatched++;
            $display("FAIL rst_mid: gnt=%b nd=%b din=%h, required 0", gnt, new_data, din);
        end
        req = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (done !== '0) begin
                mismatched++;
                $display("FAIL rst_no_done: done=%b, required 0", done);
            end
        end
        rst  = 1'b1;
        rr_m = 0;
        req_din[1*DW +: DW] = DW'($urandom);
        req_din[3*DW +: DW] = DW'($urandom);
        req = 4'b1010;
        serve(1'b1, 1'b0, who);
        compared++;
        if (who !== 1) begin
            mismatched++;
            $display("FAIL rst_rr: got %0d, required 1", who);
        end
        serve(1'b1, 1'b0, who);
    endtask

    task automatic test_random();
        int who;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req_din[i*DW +: DW] = DW'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            serve($urandom_range(0, 3) != 0, 1'b0, who);
        end
        for (int i = 0; i < 2 * N && req != '0; i++) serve(1'b1, 1'b0, who);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t;
        bit seen_done;
        apply_reset();
        spi_hold = 1'b1;
        req = 4'b1000;
        t = 0;
        while (gnt === '0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        seen_done = 1'b0;
        do begin
            @(negedge clk);
            t++;
            if (done !== '0) seen_done = 1'b1;
        end while (err === '0 && t < 200);
        compared++;
        if (t !== TMO || err !== 4'b1000 || gnt !== '0 || seen_done) begin
            mismatched++;
            $display("FAIL timeout: cycles=%0d err=%b gnt=%b done_seen=%b, required %0d 1000 0000 0", t, err, gnt, seen_done, TMO);
        end
        req = '0;
        spi_hold = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mid_change();
        test_rst_mid();
        test_random();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
